game_manager: RTL
=================

# game_manager

Parametrised round/level controller for the Frogger top level. It generalises the single-register level counter into a full game state machine with lives, round timer, BCD score and per-lane speed generation for any lane count. It sits between the collisions block and the frog/car instances: it consumes collision flags and the frame tick, and drives the round reset, lane speeds and display values.

## Interface
- NUM_LANES, 10, number of car lanes driven
- SPEED_W, 4, width of one lane speed value
- BASE_SPEED, {10{4'd11}}, packed NUM_LANES*SPEED_W; lane i base speed at bits [i*SPEED_W +: SPEED_W]
- MIN_SPEED, 1, floor for every lane speed
- MAX_LEVEL, 8, highest level (≤9, shown on one digit)
- LIVES, 3, lives per game (≥1)
- TIME_LIMIT, 1800, ticks allowed per round
- HOLD_TICKS, 60, ticks spent in DYING and LEVEL_UP
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle clock-enable pulse (ClockDivider output)
- start  in  1  start/restart request, level-sensitive
- death_collision  in  1  frog hit car/water
- win_collision  in  1  frog reached goal row
- round_reset  out  1  holds frog and cars at start positions
- state  out  3  current FSM state (package encoding)
- level  out  4  current level, 1..MAX_LEVEL
- lives  out  clog2(LIVES+1)  remaining lives
- time_left  out  clog2(TIME_LIMIT+1)  ticks left in round
- score  out  16  4 BCD digits, [15:12] most significant
- lane_speed  out  NUM_LANES*SPEED_W  per-lane speed, same packing as BASE_SPEED
- game_over  out  1  high in GAME_OVER

## Operation
- States: IDLE, PLAY, DYING, LEVEL_UP, GAME_OVER. Reset → IDLE; level=1, lives=LIVES, score=0, time_left=TIME_LIMIT, hold counter 0.
- IDLE/GAME_OVER: start=1 → PLAY; level=1, lives=LIVES, score=0, time_left=TIME_LIMIT.
- PLAY: on tick, time_left decrements. death_collision, or time_left==0, → DYING with lives−1. Otherwise win_collision → LEVEL_UP.
- Simultaneous death and win: death wins, score unchanged.
- LEVEL_UP entry: score += level, BCD, saturating at 9999. level+1, saturating at MAX_LEVEL; no wrap.
- DYING/LEVEL_UP: count HOLD_TICKS ticks, then → PLAY with time_left=TIME_LIMIT. Exception: DYING with lives==0 → GAME_OVER.
- Collision inputs are ignored outside PLAY. start is ignored in PLAY/DYING/LEVEL_UP.
- Outputs:
  - round_reset = (state != PLAY), registered.
  - game_over = (state == GAME_OVER).
- lane_speed[i] = max(BASE_SPEED[i] − level, MIN_SPEED). Unsigned subtraction must not underflow; clamp before it wraps.

## Timing
- All state and outputs registered on rising clk.
- Collision sampled at edge N → state, lives, score, round_reset change at edge N (visible cycle N+1).
- lane_speed lags level by exactly one cycle.
- Timer and hold counters advance only on cycles with tick=1; tick coincident with a collision: collision takes priority, timer not decremented.
- reset wins over every other input in any state, including mid-hold.
- Reset values:
  - round_reset=1, state=IDLE, game_over=0.
  - lane_speed = speeds for level 1.

## Structure
- Package frogger_pkg:
  - state encoding (3-bit enum)
  - BCD digit type
  - default MAX_LEVEL/LIVES/TIME_LIMIT constants, shared with frogger top and display_numbers
- Sub-module bcd_score_adder:
  - 4-digit BCD + one-digit addend, combinational
  - carry chain, with saturation to 9999

## Test plan
- Reset then start=1 for 1 cycle → state=PLAY, level=1, lives=3, score=0x0000, round_reset=0 next cycle.
- Three successive win_collision pulses in PLAY, HOLD_TICKS elapsed each time → level=4, score=0x0006, lane_speed lane0 = 11−4 = 7.
- death_collision and win_collision same cycle → DYING, lives 3→2, score and level unchanged.
- No collision for TIME_LIMIT ticks → DYING on timeout. Third death → GAME_OVER, game_over=1. start → fresh game.
- Preload score 0x9998 via wins at level 8 → score saturates 0x9999. Level stays 8. lane_speed clamps to MIN_SPEED when BASE_SPEED ≤ level.
- reset asserted mid-DYING hold → IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: game FSM encoding, BCD digit type and the default
// game constants also used by the frogger top level and display_numbers.
package frogger_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLAY      = 3'd1,
      ST_DYING     = 3'd2,
      ST_LEVEL_UP  = 3'd3,
      ST_GAME_OVER = 3'd4
   } game_state_e;

   typedef logic [3:0] bcd_digit_t;

   localparam int unsigned DEF_MAX_LEVEL  = 8;
   localparam int unsigned DEF_LIVES      = 3;
   localparam int unsigned DEF_TIME_LIMIT = 1800;
   localparam int unsigned DEF_HOLD_TICKS = 60;

endpackage

// File: rtl/bcd_score_adder.sv
// Adds a single BCD digit to a 4-digit BCD score; a carry out of the top digit
// saturates the result at 9999.
module bcd_score_adder
   import frogger_pkg::*;
(
   input  logic [15:0] i_score,
   input  bcd_digit_t  i_addend,
   output logic [15:0] o_score
);

   logic [4:0]  w_carry;
   logic [4:0]  w_sum;
   logic [15:0] w_raw;

   // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
   always_comb begin
      w_carry = '0;
      w_sum   = '0;
      w_raw   = '0;
      for (int d = 0; d < 4; d++) begin
         w_sum = {1'b0, i_score[d*4 +: 4]} + {4'd0, w_carry[d]}
               + ((d == 0) ? {1'b0, i_addend} : 5'd0);
         if (w_sum > 5'd9) begin
            w_raw[d*4 +: 4] = 4'(w_sum - 5'd10);
            w_carry[d+1]    = 1'b1;
         end else begin
            w_raw[d*4 +: 4] = w_sum[3:0];
         end
      end
      o_score = w_carry[4] ? 16'h9999 : w_raw;
   end

endmodule

// File: rtl/game_manager.sv
// Frogger game controller: IDLE/PLAY/DYING/LEVEL_UP/GAME_OVER FSM with lives,
// round timer, saturating BCD score and per-lane car speeds derived from level.
module game_manager
   import frogger_pkg::*;
#(
   parameter int unsigned                    NUM_LANES  = 10,
   parameter int unsigned                    SPEED_W    = 4,
   parameter logic [NUM_LANES*SPEED_W-1:0]   BASE_SPEED = {10{4'd11}},
   parameter int unsigned                    MIN_SPEED  = 1,
   parameter int unsigned                    MAX_LEVEL  = DEF_MAX_LEVEL,
   parameter int unsigned                    LIVES      = DEF_LIVES,
   parameter int unsigned                    TIME_LIMIT = DEF_TIME_LIMIT,
   parameter int unsigned                    HOLD_TICKS = DEF_HOLD_TICKS
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               tick,
   input  logic                               start,
   input  logic                               death_collision,
   input  logic                               win_collision,
   output logic                               round_reset,
   output logic [2:0]                         state,
   output logic [3:0]                         level,
   output logic [$clog2(LIVES+1)-1:0]         lives,
   output logic [$clog2(TIME_LIMIT+1)-1:0]    time_left,
   output logic [15:0]                        score,
   output logic [NUM_LANES*SPEED_W-1:0]       lane_speed,
   output logic                               game_over
);

   localparam int unsigned LIVES_W   = $clog2(LIVES+1);
   localparam int unsigned TIME_W    = $clog2(TIME_LIMIT+1);
   localparam int unsigned HOLD_W    = $clog2(HOLD_TICKS+1);
   localparam int unsigned LANE_BITS = NUM_LANES*SPEED_W;
   localparam int unsigned EXT_W     = ((SPEED_W > 4) ? SPEED_W : 4) + 1;

   localparam logic [3:0]         LEVEL_MAX  = 4'(MAX_LEVEL);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(TIME_LIMIT);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS-1);

   // Operands are widened so base - level is only formed when it cannot wrap.
   function automatic logic [LANE_BITS-1:0] lane_speeds(input logic [3:0] lvl);
      logic [EXT_W-1:0] base_x;
      logic [EXT_W-1:0] lvl_x;
      logic [EXT_W-1:0] min_x;
      lane_speeds = '0;
      lvl_x       = EXT_W'(lvl);
      min_x       = EXT_W'(MIN_SPEED);
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         base_x = EXT_W'(BASE_SPEED[i*SPEED_W +: SPEED_W]);
         if (base_x >= lvl_x + min_x)
            lane_speeds[i*SPEED_W +: SPEED_W] = SPEED_W'(base_x - lvl_x);
         else
            lane_speeds[i*SPEED_W +: SPEED_W] = SPEED_W'(MIN_SPEED);
      end
   endfunction

   game_state_e            r_state, w_next_state;
   logic [3:0]             r_level, w_next_level;
   logic [LIVES_W-1:0]     r_lives, w_next_lives;
   logic [TIME_W-1:0]      r_time_left, w_next_time;
   logic [HOLD_W-1:0]      r_hold, w_next_hold;
   logic [15:0]            r_score, w_next_score;
   logic [15:0]            w_score_sum;
   logic [LANE_BITS-1:0]   r_lane_speed;
   logic                   r_round_reset;
   logic                   r_game_over;

   bcd_score_adder u_score_adder (
      .i_score  (r_score),
      .i_addend (r_level),
      .o_score  (w_score_sum)
   );

   always_comb begin
      w_next_state = r_state;
      w_next_level = r_level;
      w_next_lives = r_lives;
      w_next_time  = r_time_left;
      w_next_hold  = r_hold;
      w_next_score = r_score;

      unique case (r_state)
         ST_IDLE, ST_GAME_OVER: begin
            if (start) begin
               w_next_state = ST_PLAY;
               w_next_level = 4'd1;
               w_next_lives = LIVES_INIT;
               w_next_score = '0;
               w_next_time  = TIME_INIT;
               w_next_hold  = '0;
            end
         end
         ST_PLAY: begin
            // Death outranks win and a coincident tick.
            if (death_collision || (r_time_left == '0)) begin
               w_next_state = ST_DYING;
               w_next_lives = r_lives - LIVES_W'(1);
               w_next_hold  = '0;
            end else if (win_collision) begin
               w_next_state = ST_LEVEL_UP;
               w_next_score = w_score_sum;
               w_next_level = (r_level >= LEVEL_MAX) ? r_level : r_level + 4'd1;
               w_next_hold  = '0;
            end else if (tick) begin
               w_next_time  = r_time_left - TIME_W'(1);
            end
         end
         ST_DYING, ST_LEVEL_UP: begin
            if (tick) begin
               if (r_hold == HOLD_LAST) begin
                  w_next_hold  = '0;
                  w_next_time  = TIME_INIT;
                  w_next_state = ((r_state == ST_DYING) && (r_lives == '0))
                                 ? ST_GAME_OVER : ST_PLAY;
               end else begin
                  w_next_hold  = r_hold + HOLD_W'(1);
               end
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_level       <= 4'd1;
         r_lives       <= LIVES_INIT;
         r_time_left   <= TIME_INIT;
         r_hold        <= '0;
         r_score       <= '0;
         r_lane_speed  <= lane_speeds(4'd1);
         r_round_reset <= 1'b1;
         r_game_over   <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_level       <= w_next_level;
         r_lives       <= w_next_lives;
         r_time_left   <= w_next_time;
         r_hold        <= w_next_hold;
         r_score       <= w_next_score;
         r_lane_speed  <= lane_speeds(r_level);
         r_round_reset <= (w_next_state != ST_PLAY);
         r_game_over   <= (w_next_state == ST_GAME_OVER);
      end
   end

   assign state       = r_state;
   assign level       = r_level;
   assign lives       = r_lives;
   assign time_left   = r_time_left;
   assign score       = r_score;
   assign lane_speed  = r_lane_speed;
   assign round_reset = r_round_reset;
   assign game_over   = r_game_over;

endmodule
